// File: rtl/reg_bank_alloc.sv
// Single-bank register store: valid-tracked slots, lowest-free allocation on write,
// 1-cycle registered reads with optional invalidate, occupancy and overflow reporting.
module reg_bank_alloc #(
   parameter int WORD_L         = 32,
   parameter int DEPTH          = 256,
   parameter int SIMPLE_INVALID = 1,
   parameter int ADDR_L         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_L-1:0] wr_data,
   output logic [ADDR_L-1:0] free_addr,
   output logic              free_vld,
   output logic              wr_overflow,
   input  logic              rd_en,
   input  logic [ADDR_L-1:0] rd_addr,
   input  logic              rd_invalidate,
   output logic [WORD_L-1:0] rd_data,
   output logic              rd_data_vld,
   output logic              rd_err,
   output logic [ADDR_L:0]   occupancy,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_L:0] DEPTH_C = (ADDR_L+1)'(DEPTH);

   logic [WORD_L-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid_reg;
   logic [DEPTH-1:0]  valid_next;
   logic [DEPTH-1:0]  alloc_mask;
   logic [ADDR_L:0]   occupancy_reg;
   logic [ADDR_L:0]   occupancy_next;
   logic [ADDR_L-1:0] free_addr_next;
   logic [WORD_L-1:0] rd_data_reg;
   logic              rd_data_vld_reg;
   logic              rd_err_reg;
   logic              wr_overflow_reg;
   logic              rd_slot_valid;
   logic              inv_hit;
   logic              wr_accept;

   assign rd_slot_valid = valid_reg[rd_addr];
   assign inv_hit       = rd_en & rd_invalidate & rd_slot_valid;

   // In bypass mode a slot being invalidated this cycle may be reallocated in the same cycle.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
         if (SIMPLE_INVALID != 0) begin : g_simple
            assign alloc_mask[gi] = ~valid_reg[gi];
         end else begin : g_bypass
            assign alloc_mask[gi] = ~valid_reg[gi] | (inv_hit & (rd_addr == ADDR_L'(gi)));
         end
      end
   endgenerate

   always_comb begin
      free_addr_next = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (alloc_mask[i]) free_addr_next = ADDR_L'(i);
      end
   end

   assign free_addr = free_addr_next;
   assign free_vld  = |alloc_mask;
   assign wr_accept = wr_en & free_vld;

   // Clear first, then set: a bypassed write to the invalidated slot keeps it valid.
   always_comb begin
      valid_next = valid_reg;
      if (inv_hit)   valid_next[rd_addr]        = 1'b0;
      if (wr_accept) valid_next[free_addr_next] = 1'b1;
      occupancy_next = occupancy_reg + (ADDR_L+1)'(wr_accept) - (ADDR_L+1)'(inv_hit);
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem[free_addr_next] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_reg       <= '0;
         occupancy_reg   <= '0;
         rd_data_reg     <= '0;
         rd_data_vld_reg <= 1'b0;
         rd_err_reg      <= 1'b0;
         wr_overflow_reg <= 1'b0;
      end else begin
         valid_reg       <= valid_next;
         occupancy_reg   <= occupancy_next;
         wr_overflow_reg <= wr_en & ~free_vld;
         rd_data_vld_reg <= rd_en & rd_slot_valid;
         rd_err_reg      <= rd_en & ~rd_slot_valid;
         if (rd_en) begin
            rd_data_reg <= rd_slot_valid ? mem[rd_addr] : '0;
         end
      end
   end

   assign rd_data     = rd_data_reg;
   assign rd_data_vld = rd_data_vld_reg;
   assign rd_err      = rd_err_reg;
   assign wr_overflow = wr_overflow_reg;
   assign occupancy   = occupancy_reg;
   assign full        = (occupancy_reg == DEPTH_C);
   assign empty       = (occupancy_reg == '0);

endmodule

// File: tb/tb_reg_bank_alloc.sv
// Directed bench: instance 0 uses SIMPLE_INVALID=1, instance 1 uses bypass mode (SIMPLE_INVALID=0);
// both receive identical stimulus, DEPTH=4, WORD_L=32.
module tb_reg_bank_alloc;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [1:0]  rd_addr;
   logic        rd_invalidate;

   logic [1:0]  free_addr   [2];
   logic        free_vld    [2];
   logic        wr_overflow [2];
   logic [31:0] rd_data     [2];
   logic        rd_data_vld [2];
   logic        rd_err      [2];
   logic [2:0]  occupancy   [2];
   logic        full        [2];
   logic        empty       [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_bank_alloc #(.WORD_L(32), .DEPTH(4), .SIMPLE_INVALID(1)) u_si1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .free_addr(free_addr[0]), .free_vld(free_vld[0]), .wr_overflow(wr_overflow[0]),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_invalidate(rd_invalidate),
      .rd_data(rd_data[0]), .rd_data_vld(rd_data_vld[0]), .rd_err(rd_err[0]),
      .occupancy(occupancy[0]), .full(full[0]), .empty(empty[0]));

   reg_bank_alloc #(.WORD_L(32), .DEPTH(4), .SIMPLE_INVALID(0)) u_si0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .free_addr(free_addr[1]), .free_vld(free_vld[1]), .wr_overflow(wr_overflow[1]),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_invalidate(rd_invalidate),
      .rd_data(rd_data[1]), .rd_data_vld(rd_data_vld[1]), .rd_err(rd_err[1]),
      .occupancy(occupancy[1]), .full(full[1]), .empty(empty[1]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_invalidate = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      tick(); tick();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (occupancy[d] !== 3'd0 || empty[d] !== 1'b1 || full[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_occ inst=%0d occ=%0d empty=%b full=%b need 0/1/0", d, occupancy[d], empty[d], full[d]);
         end
         checks++;
         if (free_addr[d] !== 2'd0 || free_vld[d] !== 1'b1) begin
            failures++;
            $display("FAIL reset_free inst=%0d addr=%0d vld=%b need 0/1", d, free_addr[d], free_vld[d]);
         end
         checks++;
         if (rd_data[d] !== 32'h0 || rd_data_vld[d] !== 1'b0 || rd_err[d] !== 1'b0 || wr_overflow[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs inst=%0d data=%h vld=%b err=%b ovf=%b need 0", d, rd_data[d], rd_data_vld[d], rd_err[d], wr_overflow[d]);
         end
      end
      $display("reset: occ=%0d/%0d", occupancy[0], occupancy[1]);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 32'hA0 + 32'(i);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (free_addr[d] !== 2'(i)) begin
               failures++;
               $display("FAIL fill_addr inst=%0d got=%0d need=%0d", d, free_addr[d], i);
            end
         end
         $display("write data=%h addr=%0d", wr_data, free_addr[0]);
         tick();
      end
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (full[d] !== 1'b1 || occupancy[d] !== 3'd4 || free_vld[d] !== 1'b0) begin
            failures++;
            $display("FAIL fill_full inst=%0d full=%b occ=%0d free_vld=%b need 1/4/0", d, full[d], occupancy[d], free_vld[d]);
         end
      end
      wr_en = 1'b1; wr_data = 32'hEE;
      tick();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (wr_overflow[d] !== 1'b1 || occupancy[d] !== 3'd4) begin
            failures++;
            $display("FAIL overflow inst=%0d ovf=%b occ=%0d need 1/4", d, wr_overflow[d], occupancy[d]);
         end
      end
      $display("write data=ee dropped ovf=%b/%b", wr_overflow[0], wr_overflow[1]);
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (wr_overflow[d] !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pulse inst=%0d ovf=%b need 0", d, wr_overflow[d]);
         end
      end
   endtask

   task automatic test_read();
      rd_en = 1'b1; rd_addr = 2'd2;
      tick();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_data[d] !== 32'hA2 || rd_data_vld[d] !== 1'b1 || rd_err[d] !== 1'b0 || occupancy[d] !== 3'd4) begin
            failures++;
            $display("FAIL read2 inst=%0d data=%h vld=%b err=%b occ=%0d need a2/1/0/4", d, rd_data[d], rd_data_vld[d], rd_err[d], occupancy[d]);
         end
      end
      $display("read addr=2 data=%h", rd_data[0]);
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_data[d] !== 32'hA2 || rd_data_vld[d] !== 1'b0) begin
            failures++;
            $display("FAIL read_hold inst=%0d data=%h vld=%b need a2/0", d, rd_data[d], rd_data_vld[d]);
         end
      end
   endtask

   task automatic test_inv_reuse();
      rd_en = 1'b1; rd_addr = 2'd1; rd_invalidate = 1'b1; wr_en = 1'b1; wr_data = 32'hB1;
      #1;
      checks++;
      if (free_vld[0] !== 1'b0 || free_vld[1] !== 1'b1 || free_addr[1] !== 2'd1) begin
         failures++;
         $display("FAIL bypass_mask vld0=%b vld1=%b addr1=%0d need 0/1/1", free_vld[0], free_vld[1], free_addr[1]);
      end
      tick();
      idle();
      checks++;
      if (wr_overflow[0] !== 1'b1 || rd_data[0] !== 32'hA1 || occupancy[0] !== 3'd3 || free_addr[0] !== 2'd1 || free_vld[0] !== 1'b1) begin
         failures++;
         $display("FAIL simple_inv ovf=%b data=%h occ=%0d faddr=%0d fvld=%b need 1/a1/3/1/1", wr_overflow[0], rd_data[0], occupancy[0], free_addr[0], free_vld[0]);
      end
      checks++;
      if (wr_overflow[1] !== 1'b0 || rd_data[1] !== 32'hA1 || rd_data_vld[1] !== 1'b1 || occupancy[1] !== 3'd4 || full[1] !== 1'b1) begin
         failures++;
         $display("FAIL bypass_inv ovf=%b data=%h vld=%b occ=%0d full=%b need 0/a1/1/4/1", wr_overflow[1], rd_data[1], rd_data_vld[1], occupancy[1], full[1]);
      end
      $display("invalidate addr=1 + write b1: occ=%0d/%0d", occupancy[0], occupancy[1]);
      rd_en = 1'b1; rd_addr = 2'd1;
      tick();
      idle();
      checks++;
      if (rd_data[1] !== 32'hB1 || rd_data_vld[1] !== 1'b1) begin
         failures++;
         $display("FAIL bypass_data data=%h vld=%b need b1/1", rd_data[1], rd_data_vld[1]);
      end
      checks++;
      if (rd_err[0] !== 1'b1 || rd_data[0] !== 32'h0 || rd_data_vld[0] !== 1'b0) begin
         failures++;
         $display("FAIL simple_slot_gone err=%b data=%h vld=%b need 1/0/0", rd_err[0], rd_data[0], rd_data_vld[0]);
      end
      $display("read addr=1 data=%h/%h", rd_data[0], rd_data[1]);
   endtask

   task automatic test_invalid_read();
      rd_en = 1'b1; rd_addr = 2'd3; rd_invalidate = 1'b1;
      tick();
      idle();
      checks++;
      if (rd_data[0] !== 32'hA3 || rd_data[1] !== 32'hA3 || occupancy[0] !== 3'd2 || occupancy[1] !== 3'd3) begin
         failures++;
         $display("FAIL inv3 data=%h/%h occ=%0d/%0d need a3/a3/2/3", rd_data[0], rd_data[1], occupancy[0], occupancy[1]);
      end
      checks++;
      if (free_addr[0] !== 2'd1 || free_addr[1] !== 2'd3) begin
         failures++;
         $display("FAIL inv3_free addr=%0d/%0d need 1/3", free_addr[0], free_addr[1]);
      end
      rd_en = 1'b1; rd_addr = 2'd3; rd_invalidate = 1'b1;
      tick();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (rd_err[d] !== 1'b1 || rd_data_vld[d] !== 1'b0 || rd_data[d] !== 32'h0 || occupancy[d] !== 3'(3 - (d == 0 ? 1 : 0))) begin
            failures++;
            $display("FAIL inv_invalid inst=%0d err=%b vld=%b data=%h occ=%0d", d, rd_err[d], rd_data_vld[d], rd_data[d], occupancy[d]);
         end
      end
      $display("reread invalid addr=3 err=%b/%b", rd_err[0], rd_err[1]);
   endtask

   task automatic test_back_to_back();
      wr_en = 1'b1; wr_data = 32'hC0; rd_en = 1'b1; rd_addr = 2'd0;
      tick();
      idle();
      checks++;
      if (rd_data[0] !== 32'hA0 || rd_data[1] !== 32'hA0 || occupancy[0] !== 3'd3 || occupancy[1] !== 3'd4) begin
         failures++;
         $display("FAIL b2b data=%h/%h occ=%0d/%0d need a0/a0/3/4", rd_data[0], rd_data[1], occupancy[0], occupancy[1]);
      end
      rd_en = 1'b1; rd_addr = 2'd1;
      tick();
      rd_addr = 2'd3;
      checks++;
      if (rd_data[0] !== 32'hC0 || rd_data_vld[0] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_new0 data=%h vld=%b need c0/1", rd_data[0], rd_data_vld[0]);
      end
      tick();
      idle();
      checks++;
      if (rd_data[1] !== 32'hC0 || rd_data_vld[1] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_new1 data=%h vld=%b need c0/1", rd_data[1], rd_data_vld[1]);
      end
      $display("write c0 with read addr=0 occ=%0d/%0d", occupancy[0], occupancy[1]);
   endtask

   task automatic test_reset_mid();
      wr_en = 1'b1; wr_data = 32'hDD; rd_en = 1'b1; rd_addr = 2'd0; rst = 1'b0;
      tick();
      idle();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (occupancy[d] !== 3'd0 || empty[d] !== 1'b1 || free_addr[d] !== 2'd0 || rd_data[d] !== 32'h0 ||
             rd_data_vld[d] !== 1'b0 || rd_err[d] !== 1'b0 || wr_overflow[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid inst=%0d occ=%0d empty=%b faddr=%0d data=%h vld=%b err=%b ovf=%b",
                     d, occupancy[d], empty[d], free_addr[d], rd_data[d], rd_data_vld[d], rd_err[d], wr_overflow[d]);
         end
      end
      $display("reset mid-stream occ=%0d/%0d", occupancy[0], occupancy[1]);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #2;
      test_reset();
      test_fill();
      test_read();
      test_inv_reuse();
      test_invalid_read();
      test_back_to_back();
      test_reset_mid();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
